// File: rtl/cut_sequencer_param_if.sv
// Bus between the operator config/switch logic (master) and the cut
// sequencer (slave).
//   start/abort/hold      : operator controls
//   seg_len/num_seg_m1/layers : job configuration, captured on start
//   feed/cut              : actuator enables toward the drivers
//   busy/done             : job handshake
//   seg_idx/layer_cnt/feed_cnt : progress counters for display/debug
interface cut_sequencer_param_if #(
  parameter int LEN_W     = 8,
  parameter int NUM_SEG   = 4,
  parameter int SEG_IDX_W = 2,
  parameter int LAYER_W   = 4
);
  logic                       start;
  logic                       abort;
  logic                       hold;
  logic [NUM_SEG*LEN_W-1:0]   seg_len;
  logic [SEG_IDX_W-1:0]       num_seg_m1;
  logic [LAYER_W-1:0]         layers;
  logic                       feed;
  logic                       cut;
  logic                       busy;
  logic                       done;
  logic [SEG_IDX_W-1:0]       seg_idx;
  logic [LAYER_W-1:0]         layer_cnt;
  logic [LEN_W-1:0]           feed_cnt;

  modport master (
    output start, abort, hold, seg_len, num_seg_m1, layers,
    input  feed, cut, busy, done, seg_idx, layer_cnt, feed_cnt
  );

  modport slave (
    input  start, abort, hold, seg_len, num_seg_m1, layers,
    output feed, cut, busy, done, seg_idx, layer_cnt, feed_cnt
  );
endinterface

// File: rtl/cut_sequencer_param.sv
// Parametrised cloth cut sequencer. For each layer it walks the active
// segment slots: feeds cloth for seg_len cycles (pausable with hold), then
// fires a PULSE_W-cycle cut. Zero-length slots are skipped without a cut.
// Ports:
//   CLK  : rising-edge clock
//   CLR  : asynchronous active-high clear
//   bus  : cut_sequencer_param_if slave (controls, config, actuator
//          enables, handshake and progress counters; all outputs registered)
module cut_sequencer_param #(
  parameter int LEN_W     = 8,
  parameter int NUM_SEG   = 4,
  parameter int SEG_IDX_W = 2,
  parameter int LAYER_W   = 4,
  parameter int PULSE_W   = 2
) (
  input  logic                  CLK,
  input  logic                  CLR,
  cut_sequencer_param_if.slave  bus
);

  localparam int PCNT_W = (PULSE_W > 1) ? $clog2(PULSE_W) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_FEED = 2'd1;
  localparam logic [1:0] S_CUT  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]           state, st_n;
  logic [LEN_W-1:0]     seg_sh [NUM_SEG];
  logic [SEG_IDX_W-1:0] nseg_sh, nseg_clamped;
  logic [LAYER_W-1:0]   layers_sh;
  logic [PCNT_W-1:0]    pcnt_q, pcnt_n;
  logic                 feed_q, cut_q, busy_q, done_q;
  logic                 feed_n, cut_n, busy_n, done_n;
  logic [SEG_IDX_W-1:0] seg_q, seg_n;
  logic [LAYER_W-1:0]   lay_q, lay_n;
  logic [LEN_W-1:0]     fcnt_q, fcnt_n;
  logic                 latch, advance;

  // Segment/layer step taken at the end of a cut or a skipped slot.
  logic                 last_seg, adv_done;
  logic [SEG_IDX_W-1:0] adv_idx;
  logic [LAYER_W-1:0]   adv_layer;
  logic [LEN_W-1:0]     cur_len, adv_len;

  assign nseg_clamped = (int'(bus.num_seg_m1) > NUM_SEG - 1)
                        ? SEG_IDX_W'(NUM_SEG - 1) : bus.num_seg_m1;

  assign cur_len   = seg_sh[seg_q];
  assign last_seg  = (seg_q == nseg_sh);
  assign adv_idx   = last_seg ? '0 : seg_q + 1'b1;
  assign adv_layer = last_seg ? lay_q + 1'b1 : lay_q;
  assign adv_done  = last_seg && (adv_layer == layers_sh);
  assign adv_len   = seg_sh[adv_idx];

  // Outputs are computed for the cycle being entered, so the registers
  // below hold exactly what the actuators see; hold sampled at an edge
  // therefore decides whether the following FEED cycle is a fed one.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    st_n    = state;
    feed_n  = 1'b0;
    cut_n   = 1'b0;
    busy_n  = 1'b0;
    done_n  = 1'b0;
    seg_n   = seg_q;
    lay_n   = lay_q;
    fcnt_n  = fcnt_q;
    pcnt_n  = pcnt_q;
    latch   = 1'b0;
    advance = 1'b0;

    case (state)
      S_IDLE: begin
        if (bus.start && !bus.abort) begin
          latch  = 1'b1;
          seg_n  = '0;
          lay_n  = '0;
          fcnt_n = '0;
          if (bus.layers == '0) begin
            st_n   = S_DONE;
            done_n = 1'b1;
          end else begin
            st_n   = S_FEED;
            busy_n = 1'b1;
            feed_n = !bus.hold && (bus.seg_len[LEN_W-1:0] != '0);
          end
        end
      end
      S_FEED: begin
        busy_n = 1'b1;
        if (cur_len == '0) begin
          advance = 1'b1;
        end else if (feed_q) begin
          // This cycle was a fed one; the last fed cycle moves to CUT.
          if (fcnt_q == cur_len - 1'b1) begin
            st_n   = S_CUT;
            cut_n  = 1'b1;
            fcnt_n = '0;
            pcnt_n = '0;
          end else begin
            fcnt_n = fcnt_q + 1'b1;
            feed_n = !bus.hold;
          end
        end else begin
          feed_n = !bus.hold;
        end
      end
      S_CUT: begin
        if (pcnt_q == PCNT_W'(PULSE_W - 1)) begin
          advance = 1'b1;
        end else begin
          busy_n = 1'b1;
          cut_n  = 1'b1;
          pcnt_n = pcnt_q + 1'b1;
        end
      end
      S_DONE:  st_n = S_IDLE;
      default: st_n = S_IDLE;
    endcase

    if (advance) begin
      seg_n  = adv_idx;
      lay_n  = adv_layer;
      fcnt_n = '0;
      if (adv_done) begin
        st_n   = S_DONE;
        busy_n = 1'b0;
        done_n = 1'b1;
      end else begin
        st_n   = S_FEED;
        busy_n = 1'b1;
        feed_n = !bus.hold && (adv_len != '0);
      end
    end

    // Abort drops the actuators but leaves counters where they were.
    if (state != S_IDLE && bus.abort) begin
      st_n   = S_IDLE;
      feed_n = 1'b0;
      cut_n  = 1'b0;
      busy_n = 1'b0;
      done_n = 1'b0;
      seg_n  = seg_q;
      lay_n  = lay_q;
      fcnt_n = fcnt_q;
    end
  end

  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      // NOTE: the shadow config is tiny, so it is cleared too; nothing reads stale config after reset.
      state     <= S_IDLE;
      feed_q    <= 1'b0;
      cut_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      seg_q     <= '0;
      lay_q     <= '0;
      fcnt_q    <= '0;
      pcnt_q    <= '0;
      nseg_sh   <= '0;
      layers_sh <= '0;
      for (int i = 0; i < NUM_SEG; i++) seg_sh[i] <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register updates from pre-edge values.
      state  <= st_n;
      feed_q <= feed_n;
      cut_q  <= cut_n;
      busy_q <= busy_n;
      done_q <= done_n;
      seg_q  <= seg_n;
      lay_q  <= lay_n;
      fcnt_q <= fcnt_n;
      pcnt_q <= pcnt_n;
      if (latch) begin
        nseg_sh   <= nseg_clamped;
        layers_sh <= bus.layers;
        for (int i = 0; i < NUM_SEG; i++) seg_sh[i] <= bus.seg_len[i*LEN_W +: LEN_W];
      end
    end
  end

  assign bus.feed      = feed_q;
  assign bus.cut       = cut_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.seg_idx   = seg_q;
  assign bus.layer_cnt = lay_q;
  assign bus.feed_cnt  = fcnt_q;

endmodule
